// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: in-order issue and writeback controller for the execution unit.
// Dispatches decoded ops to ALU/MDU/FPU and tracks the destination register of
// each outstanding multi-cycle op. Decode is stalled on structural and register
// hazards. The single register-file write port is shared between held MDU/FPU
// results and same-cycle ALU results.
module exu_issue_ctrl (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic [1:0]  iExuOp,
  input  logic        iEnWrite,
  input  logic [4:0]  iAddrWrite,
  input  logic        iEnRead0,
  input  logic        iEnRead1,
  input  logic [4:0]  iAddrRead0,
  input  logic [4:0]  iAddrRead1,
  input  logic [31:0] iAluResult,
  input  logic        iMduDone,
  input  logic        iFpuDone,
  input  logic [31:0] iMduResult,
  input  logic [31:0] iFpuResult,
  output logic        oStall,
  output logic        oMduStart,
  output logic        oFpuStart,
  output logic        oMduBusy,
  output logic        oFpuBusy,
  output logic        oWbEn,
  output logic [4:0]  oWbAddr,
  output logic [31:0] oWbData,
  output logic [1:0]  oWbSrc
);

  // Per-unit FSM encoding. Index 0 is the MDU, index 1 the FPU.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [1:0] SrcAlu = 2'b00;
  localparam logic [1:0] SrcMdu = 2'b01;
  localparam logic [1:0] SrcFpu = 2'b10;

  logic [1:0]       opUnit;      // one-hot target unit; zero means ALU
  logic             opIsAlu;
  logic [1:0]       unitDone;
  logic [1:0][31:0] unitResult;
  logic [1:0]       unitActive;  // BUSY or HOLD
  logic [1:0]       unitInHold;
  logic [1:0]       unitHazard;
  logic [1:0][4:0]  unitDest;
  logic [1:0][31:0] unitData;
  logic [1:0]       grant;
  logic             structStall;
  logic             stallReq;
  logic             accept;

  assign unitDone   = {iFpuDone, iMduDone};
  assign unitResult = {iFpuResult, iMduResult};

  // Decode the target unit, evaluate stall conditions and arbitrate the write port
  always_comb begin
    case (iExuOp)
      2'b01:   opUnit = 2'b01;
      2'b10:   opUnit = 2'b10;
      default: opUnit = 2'b00;
    endcase
    opIsAlu     = (opUnit == 2'b00);
    structStall = |(opUnit & unitActive);
    // An ALU op can only take the port if no result was already waiting for it.
    stallReq    = iValid & (structStall | (|unitHazard) | (opIsAlu & (|unitInHold)));
    accept      = iValid & ~stallReq & ~iRst;
    // The MDU hold wins; a simultaneous FPU hold waits a cycle.
    grant[0]    = unitInHold[0] & ~iRst;
    grant[1]    = unitInHold[1] & ~unitInHold[0] & ~iRst;
  end

  for (genvar g = 0; g < 2; g++) begin : gUnit
    logic [1:0]  state;
    logic [1:0]  stateNext;
    logic [4:0]  dest;
    logic [4:0]  destNext;
    logic        wr;
    logic        wrNext;
    logic [31:0] data;
    logic [31:0] dataNext;

    // Unit state register; reset abandons any outstanding op
    always_ff @(posedge iClk) begin
      if (iRst) begin
        state <= StIdle;
        dest  <= 5'd0;
        wr    <= 1'b0;
        data  <= 32'd0;
      end else begin
        state <= stateNext;
        dest  <= destNext;
        wr    <= wrNext;
        data  <= dataNext;
      end
    end

    // Unit next-state: dispatch, completion (held or discarded) and drain
    always_comb begin
      stateNext = state;
      destNext  = dest;
      wrNext    = wr;
      dataNext  = data;
      case (state)
        StIdle: begin
          if (accept & opUnit[g]) begin
            stateNext = StBusy;
            destNext  = iAddrWrite;
            wrNext    = iEnWrite;
          end else begin
            stateNext = StIdle;
          end
        end
        StBusy: begin
          if (unitDone[g] & wr) begin
            stateNext = StHold;
            dataNext  = unitResult[g];
          end else if (unitDone[g]) begin
            stateNext = StIdle;
            wrNext    = 1'b0;
          end else begin
            stateNext = StBusy;
          end
        end
        StHold: begin
          if (grant[g]) begin
            stateNext = StIdle;
            wrNext    = 1'b0;
          end else begin
            stateNext = StHold;
          end
        end
        default: begin
          stateNext = StIdle;
          wrNext    = 1'b0;
        end
      endcase
    end

    assign unitActive[g] = (state != StIdle);
    assign unitInHold[g] = (state == StHold);
    assign unitDest[g]   = dest;
    assign unitData[g]   = data;
    // Full 5-bit compare: r0 is tracked like any other register.
    assign unitHazard[g] = (state != StIdle) & wr &
                           ((iEnRead0 & (iAddrRead0 == dest)) |
                            (iEnRead1 & (iAddrRead1 == dest)) |
                            (iEnWrite & (iAddrWrite == dest)));
  end

  // Drive stall, dispatch, busy and writeback outputs; all forced low in reset
  always_comb begin
    oStall    = stallReq & ~iRst;
    oMduStart = accept & opUnit[0];
    oFpuStart = accept & opUnit[1];
    oMduBusy  = unitActive[0] & ~iRst;
    oFpuBusy  = unitActive[1] & ~iRst;
    if (grant[0]) begin
      oWbEn   = 1'b1;
      oWbAddr = unitDest[0];
      oWbData = unitData[0];
      oWbSrc  = SrcMdu;
    end else if (grant[1]) begin
      oWbEn   = 1'b1;
      oWbAddr = unitDest[1];
      oWbData = unitData[1];
      oWbSrc  = SrcFpu;
    end else if (accept & opIsAlu & iEnWrite) begin
      oWbEn   = 1'b1;
      oWbAddr = iAddrWrite;
      oWbData = iAluResult;
      oWbSrc  = SrcAlu;
    end else begin
      oWbEn   = 1'b0;
      oWbAddr = 5'd0;
      oWbData = 32'd0;
      oWbSrc  = SrcAlu;
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_exu_issue_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic [1:0]  iExuOp;
  logic        iEnWrite;
  logic [4:0]  iAddrWrite;
  logic        iEnRead0;
  logic        iEnRead1;
  logic [4:0]  iAddrRead0;
  logic [4:0]  iAddrRead1;
  logic [31:0] iAluResult;
  logic        iMduDone;
  logic        iFpuDone;
  logic [31:0] iMduResult;
  logic [31:0] iFpuResult;
  logic        oStall;
  logic        oMduStart;
  logic        oFpuStart;
  logic        oMduBusy;
  logic        oFpuBusy;
  logic        oWbEn;
  logic [4:0]  oWbAddr;
  logic [31:0] oWbData;
  logic [1:0]  oWbSrc;

  int errors = 0;
  int checks = 0;

  exu_issue_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iExuOp(iExuOp),
    .iEnWrite(iEnWrite), .iAddrWrite(iAddrWrite),
    .iEnRead0(iEnRead0), .iEnRead1(iEnRead1),
    .iAddrRead0(iAddrRead0), .iAddrRead1(iAddrRead1),
    .iAluResult(iAluResult), .iMduDone(iMduDone), .iFpuDone(iFpuDone),
    .iMduResult(iMduResult), .iFpuResult(iFpuResult),
    .oStall(oStall), .oMduStart(oMduStart), .oFpuStart(oFpuStart),
    .oMduBusy(oMduBusy), .oFpuBusy(oFpuBusy), .oWbEn(oWbEn),
    .oWbAddr(oWbAddr), .oWbData(oWbData), .oWbSrc(oWbSrc)
  );

  always #5 iClk = ~iClk;

  logic [44:0] actOut;
  assign actOut = {oStall, oMduStart, oFpuStart, oMduBusy, oFpuBusy,
                   oWbEn, oWbAddr, oWbData, oWbSrc};

  // Reference model: each unit either has an op in flight, holds a result, or is free.
  bit          mInFlight [2];
  bit          mHasRes   [2];
  bit          mWr       [2];
  logic [4:0]  mDest     [2];
  logic [31:0] mData     [2];
  logic        mIsAlu;
  logic        mIdx;
  logic        mAccept;
  logic [44:0] expOut;

  task automatic modelEval();
    logic hazard, busyTarget, anyHeld, stall, we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [1:0] ws;
    logic u;
    mIsAlu = !((iExuOp == 2'b01) || (iExuOp == 2'b10));
    mIdx   = (iExuOp == 2'b10);
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      u = i[0];
      if ((mInFlight[u] || mHasRes[u]) && mWr[u] &&
          ((iEnRead0 && iAddrRead0 == mDest[u]) ||
           (iEnRead1 && iAddrRead1 == mDest[u]) ||
           (iEnWrite && iAddrWrite == mDest[u])))
        hazard = 1'b1;
    end
    anyHeld    = mHasRes[0] || mHasRes[1];
    busyTarget = !mIsAlu && (mInFlight[mIdx] || mHasRes[mIdx]);
    stall      = iValid && (busyTarget || hazard || (mIsAlu && anyHeld));
    mAccept    = iValid && !stall && !iRst;
    we = 1'b0; wa = 5'd0; wd = 32'd0; ws = 2'b00;
    if (mHasRes[0]) begin
      we = 1'b1; wa = mDest[0]; wd = mData[0]; ws = 2'b01;
    end else if (mHasRes[1]) begin
      we = 1'b1; wa = mDest[1]; wd = mData[1]; ws = 2'b10;
    end else if (mAccept && mIsAlu && iEnWrite) begin
      we = 1'b1; wa = iAddrWrite; wd = iAluResult; ws = 2'b00;
    end
    if (iRst)
      expOut = 45'd0;
    else
      expOut = {stall, mAccept && !mIsAlu && !mIdx, mAccept && !mIsAlu && mIdx,
                mInFlight[0] || mHasRes[0], mInFlight[1] || mHasRes[1],
                we, wa, wd, ws};
  endtask

  task automatic modelUpdate();
    if (iRst) begin
      for (int i = 0; i < 2; i++) begin
        mInFlight[i] = 1'b0; mHasRes[i] = 1'b0; mWr[i] = 1'b0;
        mDest[i] = 5'd0; mData[i] = 32'd0;
      end
    end else begin
      if (mHasRes[0]) mHasRes[0] = 1'b0;
      else if (mHasRes[1]) mHasRes[1] = 1'b0;
      if (mInFlight[0] && iMduDone) begin
        mInFlight[0] = 1'b0;
        if (mWr[0]) begin mHasRes[0] = 1'b1; mData[0] = iMduResult; end
      end
      if (mInFlight[1] && iFpuDone) begin
        mInFlight[1] = 1'b0;
        if (mWr[1]) begin mHasRes[1] = 1'b1; mData[1] = iFpuResult; end
      end
      if (mAccept && !mIsAlu) begin
        mInFlight[mIdx] = 1'b1; mDest[mIdx] = iAddrWrite; mWr[mIdx] = iEnWrite;
      end
    end
  endtask

  task automatic clearInputs();
    iRst = 1'b0; iValid = 1'b0; iExuOp = 2'b00; iEnWrite = 1'b0; iAddrWrite = 5'd0;
    iEnRead0 = 1'b0; iEnRead1 = 1'b0; iAddrRead0 = 5'd0; iAddrRead1 = 5'd0;
    iAluResult = 32'd0; iMduDone = 1'b0; iFpuDone = 1'b0;
    iMduResult = 32'd0; iFpuResult = 32'd0;
  endtask

  task automatic setOp(input logic [1:0] op, input logic enW, input logic [4:0] dst);
    iValid = 1'b1; iExuOp = op; iEnWrite = enW; iAddrWrite = dst;
  endtask

  task automatic sample();
    @(negedge iClk);
    modelEval();
  endtask

  task automatic tick();
    @(posedge iClk);
    modelUpdate();
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    iRst = 1'b1; setOp(2'b00, 1'b1, 5'd3); iAluResult = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL reset_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      checks++;
      if ({oWbEn, oStall, oMduBusy, oFpuBusy} !== 4'b0000) begin
        errors++; $display("FAIL reset_quiet c%0d: got %b expected 0000", c, {oWbEn, oStall, oMduBusy, oFpuBusy});
      end
      tick();
    end
    iRst = 1'b0;
    sample();
    checks++;
    if ({oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 5'd3, 32'h1234_5678, 2'b00}) begin
      errors++; $display("FAIL reset_first_alu: got %h expected %h", {oWbEn, oWbAddr, oWbData, oWbSrc},
                         {1'b1, 5'd3, 32'h1234_5678, 2'b00});
    end
    tick();
    clearInputs();
  endtask

  task automatic test_mdu_basic();
    logic expStart, expBusy;
    for (int c = 0; c < 6; c++) begin
      clearInputs();
      if (c == 0) setOp(2'b01, 1'b1, 5'd5);
      if (c == 3) begin iMduDone = 1'b1; iMduResult = 32'hDEAD_0001; end
      sample();
      expStart = (c == 0);
      expBusy  = (c >= 1) && (c <= 4);
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL mdu_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      checks++;
      if ({oMduStart, oMduBusy} !== {expStart, expBusy}) begin
        errors++; $display("FAIL mdu_start_busy c%0d: got %b expected %b", c, {oMduStart, oMduBusy}, {expStart, expBusy});
      end
      if (c == 4) begin
        checks++;
        if ({oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 5'd5, 32'hDEAD_0001, 2'b01}) begin
          errors++; $display("FAIL mdu_writeback: got %h expected %h", {oWbEn, oWbAddr, oWbData, oWbSrc},
                             {1'b1, 5'd5, 32'hDEAD_0001, 2'b01});
        end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_raw_hazard();
    logic [31:0] aluA, aluB, mdu;
    aluA = $urandom; aluB = $urandom; mdu = $urandom;
    for (int c = 0; c < 8; c++) begin
      clearInputs();
      if (c == 0) setOp(2'b01, 1'b1, 5'd7);
      if (c == 1) begin setOp(2'b00, 1'b1, 5'd9); iEnRead0 = 1'b1; iAddrRead0 = 5'd8; iAluResult = aluA; end
      if (c >= 2 && c <= 6) begin setOp(2'b00, 1'b1, 5'd10); iEnRead1 = 1'b1; iAddrRead1 = 5'd7; iAluResult = aluB; end
      if (c == 4) begin iMduDone = 1'b1; iMduResult = mdu; end
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL raw_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      if (c == 1) begin
        checks++;
        if ({oStall, oWbEn, oWbAddr, oWbData} !== {1'b0, 1'b1, 5'd9, aluA}) begin
          errors++; $display("FAIL raw_independent: got %h expected %h", {oStall, oWbEn, oWbAddr, oWbData}, {1'b0, 1'b1, 5'd9, aluA});
        end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (oStall !== (c <= 5)) begin
          errors++; $display("FAIL raw_stall c%0d: got %b expected %b", c, oStall, (c <= 5));
        end
      end
      if (c == 5) begin
        checks++;
        if ({oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 5'd7, mdu, 2'b01}) begin
          errors++; $display("FAIL raw_mdu_wb: got %h expected %h", {oWbEn, oWbAddr, oWbData, oWbSrc}, {1'b1, 5'd7, mdu, 2'b01});
        end
      end
      if (c == 6) begin
        checks++;
        if ({oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 5'd10, aluB, 2'b00}) begin
          errors++; $display("FAIL raw_alu_wb: got %h expected %h", {oWbEn, oWbAddr, oWbData, oWbSrc}, {1'b1, 5'd10, aluB, 2'b00});
        end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_simul_done();
    logic [31:0] resA, resB, alu;
    resA = $urandom; resB = $urandom; alu = $urandom;
    for (int c = 0; c < 7; c++) begin
      clearInputs();
      if (c == 0) setOp(2'b01, 1'b1, 5'd2);
      if (c == 1) setOp(2'b10, 1'b1, 5'd4);
      if (c == 2) begin iMduDone = 1'b1; iMduResult = resA; iFpuDone = 1'b1; iFpuResult = resB; end
      if (c >= 3 && c <= 5) begin setOp(2'b00, 1'b1, 5'd10); iAluResult = alu; end
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL simul_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      if (c == 3) begin
        checks++;
        if ({oStall, oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 1'b1, 5'd2, resA, 2'b01}) begin
          errors++; $display("FAIL simul_mdu_first: got %h expected %h", {oStall, oWbEn, oWbAddr, oWbData, oWbSrc},
                             {1'b1, 1'b1, 5'd2, resA, 2'b01});
        end
      end
      if (c == 4) begin
        checks++;
        if ({oStall, oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 1'b1, 5'd4, resB, 2'b10}) begin
          errors++; $display("FAIL simul_fpu_second: got %h expected %h", {oStall, oWbEn, oWbAddr, oWbData, oWbSrc},
                             {1'b1, 1'b1, 5'd4, resB, 2'b10});
        end
      end
      if (c == 5) begin
        checks++;
        if ({oStall, oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b0, 1'b1, 5'd10, alu, 2'b00}) begin
          errors++; $display("FAIL simul_alu_after: got %h expected %h", {oStall, oWbEn, oWbAddr, oWbData, oWbSrc},
                             {1'b0, 1'b1, 5'd10, alu, 2'b00});
        end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_struct_discard();
    logic [31:0] res;
    res = $urandom;
    for (int c = 0; c < 7; c++) begin
      clearInputs();
      if (c == 0) setOp(2'b10, 1'b0, 5'd6);
      if (c >= 1 && c <= 3) setOp(2'b10, 1'b1, 5'd11);
      if (c == 2) begin iFpuDone = 1'b1; iFpuResult = 32'hBAD0_BAD0; end
      if (c == 4) begin iFpuDone = 1'b1; iFpuResult = res; end
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL struct_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if ({oStall, oFpuStart, oWbEn} !== 3'b100) begin
          errors++; $display("FAIL struct_stall c%0d: got %b expected 100", c, {oStall, oFpuStart, oWbEn});
        end
      end
      if (c == 3) begin
        checks++;
        if ({oFpuBusy, oFpuStart, oWbEn} !== 3'b010) begin
          errors++; $display("FAIL discard_idle: got %b expected 010", {oFpuBusy, oFpuStart, oWbEn});
        end
      end
      if (c == 5) begin
        checks++;
        if ({oWbEn, oWbAddr, oWbData, oWbSrc} !== {1'b1, 5'd11, res, 2'b10}) begin
          errors++; $display("FAIL struct_fpu_wb: got %h expected %h", {oWbEn, oWbAddr, oWbData, oWbSrc}, {1'b1, 5'd11, res, 2'b10});
        end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c < 5; c++) begin
      clearInputs();
      if (c == 0) setOp(2'b01, 1'b1, 5'd12);
      if (c == 2) iRst = 1'b1;
      if (c == 3) begin iMduDone = 1'b1; iMduResult = 32'hCAFE_F00D; end
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL midrst_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      if (c >= 3) begin
        checks++;
        if ({oWbEn, oMduBusy} !== 2'b00) begin
          errors++; $display("FAIL midrst_abandon c%0d: got %b expected 00", c, {oWbEn, oMduBusy});
        end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      iRst       = ($urandom_range(0, 63) == 0);
      iValid     = ($urandom_range(0, 9) < 7);
      iExuOp     = 2'($urandom_range(0, 3));
      iEnWrite   = 1'($urandom_range(0, 1));
      iAddrWrite = 5'($urandom_range(0, 7));
      iEnRead0   = 1'($urandom_range(0, 1));
      iEnRead1   = 1'($urandom_range(0, 1));
      iAddrRead0 = 5'($urandom_range(0, 7));
      iAddrRead1 = 5'($urandom_range(0, 7));
      iAluResult = $urandom;
      iMduDone   = ($urandom_range(0, 2) == 0);
      iFpuDone   = ($urandom_range(0, 2) == 0);
      iMduResult = $urandom;
      iFpuResult = $urandom;
      sample();
      checks++;
      if (actOut !== expOut) begin
        errors++; $display("FAIL random_bundle c%0d: got %h expected %h", c, actOut, expOut);
      end
      tick();
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    @(posedge iClk);
    #1;
    test_reset();
    test_mdu_basic();
    test_raw_hazard();
    test_simul_done();
    test_struct_discard();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
